// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and the default datapath width.
package alu_pkg;

   localparam int DEFAULT_OPERAND_SIZE = 32;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_NOR   = 4'd5,
      ALU_SLT   = 4'd6,
      ALU_SLTU  = 4'd7,
      ALU_SLL   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_SRA   = 4'd10,
      ALU_PASSB = 4'd11
   } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: decodes the opcode and produces the next result,
// carry and overflow. Vectors use big-endian numbering, so bit 0 is the MSB.
module alu_comb
   import alu_pkg::*;
#(
   parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE
) (
   input  logic [3:0]              op,
   input  logic [0:OPERAND_SIZE-1] operand1,
   input  logic [0:OPERAND_SIZE-1] operand2,
   output logic [0:OPERAND_SIZE-1] next_result,
   output logic                    next_carry,
   output logic                    next_overflow
);

   localparam int SHAMT_W = $clog2(OPERAND_SIZE);

   logic [OPERAND_SIZE:0]   add_full;
   logic [OPERAND_SIZE:0]   sub_full;
   logic [0:OPERAND_SIZE-1] add_res;
   logic [0:OPERAND_SIZE-1] sub_res;
   logic [SHAMT_W-1:0]      shamt;
   logic                    lt_signed;
   logic                    lt_unsigned;

   // The extra top bit of each widened sum holds the carry out / borrow.
   assign add_full    = {1'b0, operand1} + {1'b0, operand2};
   assign sub_full    = {1'b0, operand1} - {1'b0, operand2};
   assign add_res     = add_full[OPERAND_SIZE-1:0];
   assign sub_res     = sub_full[OPERAND_SIZE-1:0];
   assign shamt       = operand2[OPERAND_SIZE-SHAMT_W +: SHAMT_W];
   assign lt_signed   = $signed(operand1) < $signed(operand2);
   assign lt_unsigned = operand1 < operand2;

   always_comb begin
      next_result   = '0;
      next_carry    = 1'b0;
      next_overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            next_result   = add_res;
            next_carry    = add_full[OPERAND_SIZE];
            next_overflow = (operand1[0] == operand2[0]) && (add_res[0] != operand1[0]);
         end
         ALU_SUB: begin
            next_result   = sub_res;
            next_carry    = sub_full[OPERAND_SIZE];
            next_overflow = (operand1[0] != operand2[0]) && (sub_res[0] != operand1[0]);
         end
         ALU_AND:   next_result = operand1 & operand2;
         ALU_OR:    next_result = operand1 | operand2;
         ALU_XOR:   next_result = operand1 ^ operand2;
         ALU_NOR:   next_result = ~(operand1 | operand2);
         ALU_SLT:   next_result = OPERAND_SIZE'(lt_signed);
         ALU_SLTU:  next_result = OPERAND_SIZE'(lt_unsigned);
         ALU_SLL:   next_result = operand1 << shamt;
         ALU_SRL:   next_result = operand1 >> shamt;
         ALU_SRA:   next_result = $signed(operand1) >>> shamt;
         ALU_PASSB: next_result = operand2;
         default:   next_result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered ALU: one operation accepted per cycle, results visible one cycle later.
module alu
   import alu_pkg::*;
#(
   parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [3:0]              op,
   input  logic [0:OPERAND_SIZE-1] operand1,
   input  logic [0:OPERAND_SIZE-1] operand2,
   output logic [0:OPERAND_SIZE-1] result,
   output logic                    zero,
   output logic                    out_valid,
   output logic                    carry,
   output logic                    overflow
);

   logic [0:OPERAND_SIZE-1] next_result;
   logic                    next_carry;
   logic                    next_overflow;

   alu_comb #(
      .OPERAND_SIZE(OPERAND_SIZE)
   ) u_alu_comb (
      .op           (op),
      .operand1     (operand1),
      .operand2     (operand2),
      .next_result  (next_result),
      .next_carry   (next_carry),
      .next_overflow(next_overflow)
   );

   // Result flags only update on accepted operations; idle cycles just drop out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         zero      <= 1'b1;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result   <= next_result;
            zero     <= ~|next_result;
            carry    <= next_carry;
            overflow <= next_overflow;
         end
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU with hand-computed expected values.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  op;
   logic [0:31] operand1;
   logic [0:31] operand2;
   logic [0:31] result;
   logic        zero;
   logic        out_valid;
   logic        carry;
   logic        overflow;

   int check_count = 0;
   int error_count = 0;

   alu #(.OPERAND_SIZE(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .op       (op),
      .operand1 (operand1),
      .operand2 (operand2),
      .result   (result),
      .zero     (zero),
      .out_valid(out_valid),
      .carry    (carry),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] exp_result,
                            input logic exp_carry, input logic exp_ovf, input logic exp_valid);
      checkOutput({tag, ".result"}, 64'(result), 64'(exp_result));
      checkOutput({tag, ".zero"}, 64'(zero), 64'(exp_result == 32'd0));
      checkOutput({tag, ".carry"}, 64'(carry), 64'(exp_carry));
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
      checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
   endtask

   // Drive one operation on the falling edge, then sample just after the accepting edge.
   task automatic applyStimulus(input string tag, input logic [3:0] op_in,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_result, input logic exp_carry,
                                input logic exp_ovf);
      @(negedge clk);
      in_valid = 1'b1;
      op       = op_in;
      operand1 = a;
      operand2 = b;
      @(posedge clk);
      #1;
      check_all(tag, exp_result, exp_carry, exp_ovf, 1'b1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      op       = 4'd0;
      operand1 = '0;
      operand2 = '0;
      #12;
      check_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("add_1_0", 4'd0, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0);
      applyStimulus("add_0_1", 4'd0, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0);
      applyStimulus("sub_5_5", 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
      applyStimulus("sub_3_5", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
      applyStimulus("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
      applyStimulus("add_max_pos", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
      applyStimulus("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
      applyStimulus("sub_min_neg", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      applyStimulus("or", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
      applyStimulus("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
      applyStimulus("nor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0);
      applyStimulus("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
      applyStimulus("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
      applyStimulus("sll_31", 4'd8, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
      applyStimulus("sll_0", 4'd8, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
      applyStimulus("srl", 4'd9, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0);
      applyStimulus("sra", 4'd10, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0);
      applyStimulus("passb", 4'd11, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1'b0);
      applyStimulus("op13", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      applyStimulus("sub_borrow", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);

      // Idle cycles: flags and result hold even though the inputs change.
      @(negedge clk);
      in_valid = 1'b0;
      op       = 4'd0;
      operand1 = 32'd7;
      operand2 = 32'd9;
      @(posedge clk);
      #1;
      check_all("idle1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_all("idle2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset between edges while out_valid is high.
      applyStimulus("pre_reset", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
      applyStimulus("pre_reset2", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_all("in_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("first_accept", 32'h8000_0000, 1'b0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

   initial begin
      #100000;
      error_count++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter OPERAND_SIZE, default 32, operand/result width in bits.
REQ-002 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands/opcode valid this cycle.
REQ-006 op  input  4  operation select, encodings per REQ-012.
REQ-007 operand1  input  [0:OPERAND_SIZE-1]  first operand A; bit 0 = MSB (big-endian numbering).
REQ-008 operand2  input  [0:OPERAND_SIZE-1]  second operand B; bit 0 = MSB.
REQ-009 result  output  [0:OPERAND_SIZE-1]  registered result; bit 0 = MSB.
REQ-010 zero  output  1  registered; 1 when result is all zeros.
REQ-011 out_valid, carry, overflow  output  1 each  registered: result valid; unsigned carry/borrow; signed overflow.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed A<B -> 1 else 0), 7 SLTU (unsigned), 8 SLL, 9 SRL, 10 SRA, 11 PASSB (result=B); 12-15 produce result 0.
REQ-013 Arithmetic modulo 2^OPERAND_SIZE; two's complement for signed ops.
REQ-014 carry: ADD = carry out of MSB; SUB = 1 when borrow (A<B unsigned); all other ops 0.
REQ-015 overflow: ADD = operands same sign, result sign differs; SUB = operands differ in sign, result sign differs from A; all other ops 0.
REQ-016 Shifts: A shifted by B's low log2(OPERAND_SIZE) bits (for 32: bits [27:31]); higher bits of B ignored; shift 0 returns A.
REQ-017 SRA fills with A bit 0 (sign); SLL/SRL fill with 0.
REQ-018 zero computed from the result value being registered, same cycle as result.
REQ-019 Latency 1: when in_valid=1 at edge N, result/zero/carry/overflow/out_valid=1 visible after edge N.
REQ-020 in_valid=0 at an edge: out_valid<=0; result, zero, carry, overflow hold previous values.
REQ-021 No back-pressure; a new operation is accepted every cycle.
REQ-022 Boundaries: 0x7FFFFFFF+1 -> 0x80000000, overflow=1, carry=0; 0xFFFFFFFF+1 -> 0, zero=1, carry=1, overflow=0.

Reset
REQ-023 On rst_n=0 (asynchronous), result=0, zero=1, carry=0, overflow=0, out_valid=0.
REQ-024 Reset asserted mid-operation discards the pending operation; first accept is at the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-025 Shared package holds op encoding constants (ALU_ADD..ALU_PASSB) and the default OPERAND_SIZE.
REQ-026 One sub-module, alu_comb: purely combinational op decode/datapath producing next result, carry, overflow; alu holds only the output registers.

Verification
REQ-027 A=1, B=0, op=ADD, in_valid=1 -> next cycle result=1, zero=0, out_valid=1; then A=0, B=1 -> result=1, zero=0.
REQ-028 op=SUB, A=5, B=5 -> result=0, zero=1, carry=0; A=3, B=5 -> result=0xFFFFFFFE, carry=1.
REQ-029 ADD A=0x7FFFFFFF, B=1 -> 0x80000000, overflow=1; ADD A=0xFFFFFFFF, B=1 -> 0, zero=1, carry=1.
REQ-030 SRA A=0x80000000, B=0x21 -> shift 1 -> 0xC0000000; SRL same -> 0x40000000; SLL A=1, B=31 -> 0x80000000.
REQ-031 SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; op=13 -> result 0, zero=1.
REQ-032 Drop rst_n between edges while out_valid=1 -> outputs go to reset values immediately; in_valid=0 cycles hold result and clear out_valid.
